// File: rtl/instructionfetch.sv
// Instruction fetch stage: loadable program memory with registered reads, a
// self-sequencing PC, a small output FIFO and decoded-field delivery to decode
// over valid/ready. Supports redirect with flush, halt detection and
// end-of-memory stop.
module instructionfetch #(
    parameter int unsigned        PC_BITS    = 12,
    parameter int unsigned        OP_BITS    = 3,
    parameter int unsigned        REG_BITS   = 3,
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [OP_BITS-1:0] HALT_OP    = {OP_BITS{1'b1}},
    parameter string              INIT_FILE  = ""
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             load_en,
    input  logic [PC_BITS-1:0]               load_addr,
    input  logic [OP_BITS+2*REG_BITS-1:0]    load_data,
    input  logic                             redirect,
    input  logic [PC_BITS-1:0]               redirect_pc,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [PC_BITS-1:0]               out_pc,
    output logic [OP_BITS-1:0]               instructions,
    output logic [REG_BITS-1:0]              reg1,
    output logic [REG_BITS-1:0]              reg2,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned INS_BITS = OP_BITS + 2*REG_BITS;
    localparam int unsigned MEM_WORDS = 1 << PC_BITS;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    logic [INS_BITS-1:0] core [MEM_WORDS];
    logic [INS_BITS-1:0] rdata_q;

    state_t              state_q, state_d;
    logic [PC_BITS-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_BITS-1:0]  rd_pc_q, rd_pc_d;
    logic                inflight_q, inflight_d;
    logic                halt_q, halt_d;
    logic                eom_q, eom_d;
    logic [INS_BITS-1:0] fifo_ins_q [FIFO_DEPTH];
    logic [INS_BITS-1:0] fifo_ins_d [FIFO_DEPTH];
    logic [PC_BITS-1:0]  fifo_pc_q [FIFO_DEPTH];
    logic [PC_BITS-1:0]  fifo_pc_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                issue, push, pop, flush, ret_halt;
    logic [OCC_W-1:0]    occ;
    logic [INS_BITS-1:0] head_ins;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Program memory: load port writes outside FETCH, one-cycle registered read on issue
    always_ff @(posedge clk) begin
        if (load_en && (state_q != S_FETCH)) core[load_addr] <= load_data;
        if (issue) rdata_q <= core[fetch_pc_q];
    end

    // Next-state, issue control and FIFO update
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = 1'b0;
        halt_d     = halt_q;
        eom_d      = eom_q;
        fifo_ins_d = fifo_ins_q;
        fifo_pc_d  = fifo_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = (count_q != '0) && out_ready;
        ret_halt   = inflight_q && (rdata_q[INS_BITS-1 -: OP_BITS] == HALT_OP);
        occ        = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    fetch_pc_d = '0;
                    halt_d     = 1'b0;
                    eom_d      = 1'b0;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    // Redirect wins over halt detection and discards the in-flight read
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    halt_d     = 1'b0;
                    eom_d      = 1'b0;
                end else begin
                    push = inflight_q;
                    if (ret_halt) halt_d = 1'b1;
                    // A returning halt suppresses the issue of any younger read
                    issue = !halt_q && !eom_q && !ret_halt && (occ < OCC_W'(FIFO_DEPTH));
                    if (issue) begin
                        inflight_d = 1'b1;
                        rd_pc_d    = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_BITS'(1);
                        if (fetch_pc_q == '1) eom_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fifo_ins_d[tail_q] = rdata_q;
                fifo_pc_d[tail_q]  = rd_pc_q;
                tail_d             = ptr_inc(tail_q);
            end
            if (pop) head_d = ptr_inc(head_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Finish on the edge that drains the last instruction after a stop
        if ((state_q == S_FETCH) && !flush && (halt_d || eom_d) &&
            (count_d == '0) && !inflight_d) begin
            state_d = S_DONE;
        end
    end

    // State registers with asynchronous reset; memory contents are retained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            halt_q     <= 1'b0;
            eom_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ins_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            halt_q     <= halt_d;
            eom_q      <= eom_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fifo_ins_q <= fifo_ins_d;
            fifo_pc_q  <= fifo_pc_d;
        end
    end

    // Head-of-FIFO presentation, zeroed when nothing is valid
    assign head_ins     = fifo_ins_q[head_q];
    assign out_valid    = (count_q != '0);
    assign out_pc       = out_valid ? fifo_pc_q[head_q] : '0;
    assign instructions = out_valid ? head_ins[INS_BITS-1 -: OP_BITS] : '0;
    assign reg1         = out_valid ? head_ins[2*REG_BITS-1 -: REG_BITS] : '0;
    assign reg2         = out_valid ? head_ins[REG_BITS-1:0] : '0;
    assign busy         = (state_q == S_FETCH);
    assign done         = (state_q == S_DONE);

endmodule
